reorder_buffer: RTL and testbench

//  Circular in-order retirement queue between decoder/issue and the architectural register file.

---
 rtl/reorder_buffer_pkg.sv | 20 ++
 rtl/reorder_buffer_if.sv | 60 ++++++
 rtl/reorder_buffer.sv | 168 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, types and helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE    = 16;
    localparam int unsigned ROB_POS_WID = $clog2(ROB_SIZE);
    localparam int unsigned ROB_ID_WID  = ROB_POS_WID + 1;  // occupancy count, holds 0..ROB_SIZE
    localparam int unsigned REG_POS_WID = 5;
    localparam int unsigned DATA_WID    = 32;

    typedef logic [ROB_POS_WID-1:0] rob_pos_t;
    typedef logic [ROB_ID_WID-1:0]  rob_cnt_t;
    typedef logic [REG_POS_WID-1:0] reg_pos_t;
    typedef logic [DATA_WID-1:0]    data_t;

    // Fetch redirect after a mispredicted branch: resolved target if taken, else fall-through.
    function automatic data_t redirect_pc(input logic real_jump, input data_t target, input data_t pc);
        return real_jump ? target : pc + data_t'(4);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, operand query, writeback and retirement signals of the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic     rob_full;
    rob_pos_t rob_tail;

    logic     issue;
    reg_pos_t issue_rd;
    logic     issue_is_store;
    logic     issue_is_br;
    logic     issue_pred_jump;
    data_t    issue_pc;

    rob_pos_t q1_pos;
    rob_pos_t q2_pos;
    logic     q1_ready;
    logic     q2_ready;
    data_t    q1_val;
    data_t    q2_val;

    logic     alu_valid;
    rob_pos_t alu_pos;
    data_t    alu_val;
    logic     alu_jump;
    data_t    alu_target;

    logic     lsb_valid;
    rob_pos_t lsb_pos;
    data_t    lsb_val;

    logic     commit;
    reg_pos_t commit_rd;
    data_t    commit_val;
    rob_pos_t commit_rob_pos;
    logic     commit_store;
    logic     rollback;
    data_t    correct_pc;

    // ROB side
    modport slave (
        input  issue, issue_rd, issue_is_store, issue_is_br, issue_pred_jump, issue_pc,
        input  q1_pos, q2_pos,
        input  alu_valid, alu_pos, alu_val, alu_jump, alu_target,
        input  lsb_valid, lsb_pos, lsb_val,
        output rob_full, rob_tail, q1_ready, q2_ready, q1_val, q2_val,
        output commit, commit_rd, commit_val, commit_rob_pos, commit_store, rollback, correct_pc
    );

    // Pipeline side (decoder, ALU, LSB, regfile, fetch)
    modport master (
        output issue, issue_rd, issue_is_store, issue_is_br, issue_pred_jump, issue_pc,
        output q1_pos, q2_pos,
        output alu_valid, alu_pos, alu_val, alu_jump, alu_target,
        output lsb_valid, lsb_pos, lsb_val,
        input  rob_full, rob_tail, q1_ready, q2_ready, q1_val, q2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos, commit_store, rollback, correct_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates at tail, captures ALU/LSB results,
// retires one ready entry per cycle from head and flushes on a branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    reorder_buffer_if.slave   rob
);

    rob_pos_t head;
    rob_pos_t tail;
    rob_cnt_t count;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] is_store;
    logic [ROB_SIZE-1:0] is_br;
    logic [ROB_SIZE-1:0] pred_jump;
    logic [ROB_SIZE-1:0] real_jump;
    reg_pos_t            rd     [ROB_SIZE];
    data_t               val    [ROB_SIZE];
    data_t               pc     [ROB_SIZE];
    data_t               target [ROB_SIZE];

    logic     commit_q;
    logic     commit_store_q;
    logic     rollback_q;
    reg_pos_t commit_rd_q;
    data_t    commit_val_q;
    rob_pos_t commit_pos_q;
    data_t    correct_pc_q;

    logic  full;
    logic  issue_ok;
    logic  do_retire;
    logic  mispredict;
    logic  q1_ready_c;
    logic  q2_ready_c;
    data_t q1_val_c;
    data_t q2_val_c;

    // Issue/retire decisions from registered state only.
    always_comb begin
        full       = (count == rob_cnt_t'(ROB_SIZE));
        issue_ok   = rob.issue && !full;
        do_retire  = (count != '0) && busy[head] && ready[head];
        mispredict = do_retire && is_br[head] && (real_jump[head] != pred_jump[head]);
    end

    // Operand lookup with same-cycle writeback forwarding; ALU has priority over LSB.
    always_comb begin
        q1_ready_c = ready[rob.q1_pos];
        q1_val_c   = val[rob.q1_pos];
        q2_ready_c = ready[rob.q2_pos];
        q2_val_c   = val[rob.q2_pos];
        if (rob.lsb_valid && rob.lsb_pos == rob.q1_pos) begin
            q1_ready_c = 1'b1;
            q1_val_c   = rob.lsb_val;
        end
        if (rob.alu_valid && rob.alu_pos == rob.q1_pos) begin
            q1_ready_c = 1'b1;
            q1_val_c   = rob.alu_val;
        end
        if (rob.lsb_valid && rob.lsb_pos == rob.q2_pos) begin
            q2_ready_c = 1'b1;
            q2_val_c   = rob.lsb_val;
        end
        if (rob.alu_valid && rob.alu_pos == rob.q2_pos) begin
            q2_ready_c = 1'b1;
            q2_val_c   = rob.alu_val;
        end
    end

    // Entry array, pointers and registered retirement outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            busy           <= '0;
            ready          <= '0;
            is_store       <= '0;
            is_br          <= '0;
            pred_jump      <= '0;
            real_jump      <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                rd[i]     <= '0;
                val[i]    <= '0;
                pc[i]     <= '0;
                target[i] <= '0;
            end
            commit_q       <= 1'b0;
            commit_store_q <= 1'b0;
            rollback_q     <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_pos_q   <= '0;
            correct_pc_q   <= '0;
        end else if (!rdy) begin
            commit_q       <= 1'b0;
            commit_store_q <= 1'b0;
            rollback_q     <= 1'b0;
        end else begin
            commit_q       <= do_retire && !is_store[head];
            commit_store_q <= do_retire && is_store[head];
            rollback_q     <= mispredict;
            if (do_retire) begin
                commit_rd_q  <= rd[head];
                commit_val_q <= val[head];
                commit_pos_q <= head;
            end
            if (mispredict) begin
                correct_pc_q <= redirect_pc(real_jump[head], target[head], pc[head]);
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                busy         <= '0;
                ready        <= '0;
            end else begin
                // Later assignments win: issue, then LSB, then ALU, then retire clear.
                if (issue_ok) begin
                    busy[tail]      <= 1'b1;
                    ready[tail]     <= 1'b0;
                    rd[tail]        <= rob.issue_rd;
                    is_store[tail]  <= rob.issue_is_store;
                    is_br[tail]     <= rob.issue_is_br;
                    pred_jump[tail] <= rob.issue_pred_jump;
                    real_jump[tail] <= 1'b0;
                    pc[tail]        <= rob.issue_pc;
                    tail            <= tail + rob_pos_t'(1);
                end
                if (rob.lsb_valid) begin
                    ready[rob.lsb_pos] <= 1'b1;
                    val[rob.lsb_pos]   <= rob.lsb_val;
                end
                if (rob.alu_valid) begin
                    ready[rob.alu_pos]     <= 1'b1;
                    val[rob.alu_pos]       <= rob.alu_val;
                    real_jump[rob.alu_pos] <= rob.alu_jump;
                    target[rob.alu_pos]    <= rob.alu_target;
                end
                if (do_retire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + rob_pos_t'(1);
                end
                count <= count + rob_cnt_t'(issue_ok) - rob_cnt_t'(do_retire);
            end
        end
    end

    assign rob.rob_full       = full;
    assign rob.rob_tail       = tail;
    assign rob.q1_ready       = q1_ready_c;
    assign rob.q1_val         = q1_val_c;
    assign rob.q2_ready       = q2_ready_c;
    assign rob.q2_val         = q2_val_c;
    assign rob.commit         = commit_q;
    assign rob.commit_store   = commit_store_q;
    assign rob.rollback       = rollback_q;
    assign rob.commit_rd      = commit_rd_q;
    assign rob.commit_val     = commit_val_q;
    assign rob.commit_rob_pos = commit_pos_q;
    assign rob.correct_pc     = correct_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table plus hand-written corner sequences.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .rob   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        issue;
        logic [4:0]  rd;
        logic        is_st;
        logic        is_br;
        logic        pred;
        logic [31:0] pc;
        logic        alu_v;
        logic [3:0]  alu_pos;
        logic [31:0] alu_val;
        logic        alu_j;
        logic [31:0] alu_tgt;
        logic        lsb_v;
        logic [3:0]  lsb_pos;
        logic [31:0] lsb_val;
        logic        q_chk;
        logic [3:0]  q1_pos;
        logic [3:0]  q2_pos;
        logic        e_q1_rdy;
        logic [31:0] e_q1_val;
        logic        e_q2_rdy;
        logic [31:0] e_q2_val;
        logic        e_commit;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic [3:0]  e_pos;
        logic [3:0]  e_tail;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t stim(logic iss, logic [4:0] rd, logic av, logic [3:0] ap, logic [31:0] aval,
                                  logic lv, logic [3:0] lp, logic [31:0] lval);
        vec_t v;
        v = '{default: '0};
        v.issue = iss;  v.rd = rd;
        v.alu_v = av;   v.alu_pos = ap; v.alu_val = aval;
        v.lsb_v = lv;   v.lsb_pos = lp; v.lsb_val = lval;
        return v;
    endfunction

    function automatic vec_t expc(vec_t vi, logic c, logic [4:0] crd, logic [31:0] cval, logic [3:0] cpos,
                                  logic [3:0] tail);
        vec_t v = vi;
        v.e_commit = c; v.e_rd = crd; v.e_val = cval; v.e_pos = cpos; v.e_tail = tail;
        return v;
    endfunction

    function automatic vec_t qry(vec_t vi, logic [3:0] p1, logic r1, logic [31:0] v1,
                                 logic [3:0] p2, logic r2, logic [31:0] v2);
        vec_t v = vi;
        v.q_chk = 1'b1;
        v.q1_pos = p1; v.e_q1_rdy = r1; v.e_q1_val = v1;
        v.q2_pos = p2; v.e_q2_rdy = r2; v.e_q2_val = v2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.issue           = v.issue;
        bus.issue_rd        = v.rd;
        bus.issue_is_store  = v.is_st;
        bus.issue_is_br     = v.is_br;
        bus.issue_pred_jump = v.pred;
        bus.issue_pc        = v.pc;
        bus.alu_valid       = v.alu_v;
        bus.alu_pos         = v.alu_pos;
        bus.alu_val         = v.alu_val;
        bus.alu_jump        = v.alu_j;
        bus.alu_target      = v.alu_tgt;
        bus.lsb_valid       = v.lsb_v;
        bus.lsb_pos         = v.lsb_pos;
        bus.lsb_val         = v.lsb_val;
        bus.q1_pos          = v.q1_pos;
        bus.q2_pos          = v.q2_pos;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        apply(stim(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_pulse(input string tag, input logic c, input logic st, input logic rb);
        chk({tag, " commit"}, 32'(bus.commit), 32'(c));
        chk({tag, " commit_store"}, 32'(bus.commit_store), 32'(st));
        chk({tag, " rollback"}, 32'(bus.rollback), 32'(rb));
    endtask

    initial begin
        vec_t v;

        // ---------------- reset / idle ----------------
        do_reset();
        chk_pulse("reset", 0, 0, 0);
        chk("reset commit_rd", 32'(bus.commit_rd), 0);
        chk("reset commit_val", bus.commit_val, 0);
        chk("reset commit_rob_pos", 32'(bus.commit_rob_pos), 0);
        chk("reset correct_pc", bus.correct_pc, 0);
        chk("reset rob_tail", 32'(bus.rob_tail), 0);
        chk("reset rob_full", 32'(bus.rob_full), 0);

        // ---------------- vector table ----------------
        // basic retire: issue+writeback together, commit one edge later
        tbl.push_back(qry(expc(stim(1, 5, 1, 0, 32'h1234, 0, 0, 0), 0, 0, 0, 0, 1), 0, 1, 32'h1234, 1, 0, 0));
        tbl.push_back(expc(stim(0, 0, 0, 0, 0, 0, 0, 0), 1, 5, 32'h1234, 0, 1));
        // in-order: three entries at pos1..3, written back 3,2,1
        tbl.push_back(expc(stim(1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 2));
        tbl.push_back(expc(stim(1, 2, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 3));
        tbl.push_back(qry(expc(stim(1, 3, 1, 3, 32'h33, 0, 0, 0), 0, 0, 0, 0, 4), 3, 1, 32'h33, 1, 0, 0));
        tbl.push_back(qry(expc(stim(0, 0, 1, 2, 32'h22, 0, 0, 0), 0, 0, 0, 0, 4), 2, 1, 32'h22, 3, 1, 32'h33));
        tbl.push_back(qry(expc(stim(0, 0, 0, 0, 0, 1, 1, 32'h11), 0, 0, 0, 0, 4), 1, 1, 32'h11, 0, 0, 0));
        tbl.push_back(expc(stim(0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 32'h11, 1, 4));
        tbl.push_back(expc(stim(0, 0, 0, 0, 0, 0, 0, 0), 1, 2, 32'h22, 2, 4));
        tbl.push_back(expc(stim(0, 0, 0, 0, 0, 0, 0, 0), 1, 3, 32'h33, 3, 4));
        // ALU and LSB hit the same entry: ALU value wins
        tbl.push_back(expc(stim(1, 7, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 5));
        tbl.push_back(qry(expc(stim(0, 0, 1, 4, 32'hAAAA, 1, 4, 32'hBBBB), 0, 0, 0, 0, 5), 4, 1, 32'hAAAA, 4, 1, 32'hAAAA));
        tbl.push_back(expc(stim(0, 0, 0, 0, 0, 0, 0, 0), 1, 7, 32'hAAAA, 4, 5));
        tbl.push_back(qry(expc(stim(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 5), 4, 0, 0, 4, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            if (tbl[i].q_chk) begin
                chk($sformatf("v%0d q1_ready", i), 32'(bus.q1_ready), 32'(tbl[i].e_q1_rdy));
                chk($sformatf("v%0d q2_ready", i), 32'(bus.q2_ready), 32'(tbl[i].e_q2_rdy));
                if (tbl[i].e_q1_rdy) chk($sformatf("v%0d q1_val", i), bus.q1_val, tbl[i].e_q1_val);
                if (tbl[i].e_q2_rdy) chk($sformatf("v%0d q2_val", i), bus.q2_val, tbl[i].e_q2_val);
            end
            step();
            chk_pulse($sformatf("v%0d", i), tbl[i].e_commit, 0, 0);
            if (tbl[i].e_commit) begin
                chk($sformatf("v%0d commit_rd", i), 32'(bus.commit_rd), 32'(tbl[i].e_rd));
                chk($sformatf("v%0d commit_val", i), bus.commit_val, tbl[i].e_val);
                chk($sformatf("v%0d commit_rob_pos", i), 32'(bus.commit_rob_pos), 32'(tbl[i].e_pos));
            end
            chk($sformatf("v%0d rob_tail", i), 32'(bus.rob_tail), 32'(tbl[i].e_tail));
            chk($sformatf("v%0d rob_full", i), 32'(bus.rob_full), 0);
        end

        // ---------------- full and wrap ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(stim(1, 5'(i + 1), 0, 0, 0, 0, 0, 0));
            step();
        end
        chk("full rob_full", 32'(bus.rob_full), 1);
        chk("full rob_tail", 32'(bus.rob_tail), 0);
        apply(stim(1, 5'd20, 0, 0, 0, 0, 0, 0));
        step();
        chk("17th rob_tail", 32'(bus.rob_tail), 0);
        chk("17th rob_full", 32'(bus.rob_full), 1);
        apply(stim(1, 5'd21, 1, 0, 32'h500, 0, 0, 0));
        step();
        chk_pulse("full wb", 0, 0, 0);
        chk("full wb rob_tail", 32'(bus.rob_tail), 0);
        // retire while full: the issue in this cycle is still refused
        apply(stim(1, 5'd22, 0, 0, 0, 0, 0, 0));
        step();
        chk_pulse("full retire", 1, 0, 0);
        chk("full retire rd", 32'(bus.commit_rd), 1);
        chk("full retire val", bus.commit_val, 32'h500);
        chk("full retire pos", 32'(bus.commit_rob_pos), 0);
        chk("full retire rob_tail", 32'(bus.rob_tail), 0);
        chk("full retire rob_full", 32'(bus.rob_full), 0);
        apply(stim(1, 5'd31, 0, 0, 0, 0, 0, 0));
        step();
        chk("wrap rob_tail", 32'(bus.rob_tail), 1);
        chk("wrap rob_full", 32'(bus.rob_full), 1);
        apply(qry(stim(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0));
        #1;
        chk("wrap pos0 not ready", 32'(bus.q1_ready), 0);
        step();
        chk_pulse("wrap idle", 0, 0, 0);

        // ---------------- mispredict, taken ----------------
        do_reset();
        v = stim(1, 1, 0, 0, 0, 0, 0, 0); v.is_br = 1; v.pred = 0; v.pc = 32'h100;
        apply(v);
        step();
        v = stim(1, 2, 0, 0, 0, 0, 0, 0); v.pc = 32'h104;
        apply(v);
        step();
        v = stim(0, 0, 1, 0, 32'h104, 0, 0, 0); v.alu_j = 1; v.alu_tgt = 32'h200;
        apply(v);
        step();
        chk_pulse("mp wb", 0, 0, 0);
        apply(stim(1, 3, 0, 0, 0, 0, 0, 0));
        step();
        chk_pulse("mp", 1, 0, 1);
        chk("mp commit_rd", 32'(bus.commit_rd), 1);
        chk("mp commit_val", bus.commit_val, 32'h104);
        chk("mp correct_pc", bus.correct_pc, 32'h200);
        chk("mp rob_tail", 32'(bus.rob_tail), 0);
        chk("mp rob_full", 32'(bus.rob_full), 0);
        apply(qry(stim(0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0));
        #1;
        chk("mp pos1 cleared", 32'(bus.q1_ready), 0);
        step();
        chk_pulse("mp after", 0, 0, 0);

        // ---------------- mispredict, not taken (issue+wb same cycle) ----------------
        v = stim(1, 0, 1, 0, 32'h304, 0, 0, 0); v.is_br = 1; v.pred = 1; v.pc = 32'h300;
        v.alu_j = 0; v.alu_tgt = 32'h999;
        apply(v);
        step();
        apply(stim(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_pulse("nt", 1, 0, 1);
        chk("nt correct_pc", bus.correct_pc, 32'h304);
        chk("nt commit_rob_pos", 32'(bus.commit_rob_pos), 0);

        // ---------------- correctly predicted branch ----------------
        v = stim(1, 6, 1, 0, 32'h404, 0, 0, 0); v.is_br = 1; v.pred = 1; v.pc = 32'h400;
        v.alu_j = 1; v.alu_tgt = 32'h800;
        apply(v);
        step();
        apply(stim(1, 8, 0, 0, 0, 0, 0, 0));
        step();
        chk_pulse("okbr", 1, 0, 0);
        chk("okbr commit_rd", 32'(bus.commit_rd), 6);
        chk("okbr commit_val", bus.commit_val, 32'h404);
        chk("okbr rob_tail", 32'(bus.rob_tail), 2);

        // ---------------- store retire and rdy freeze ----------------
        do_reset();
        v = stim(1, 9, 0, 0, 0, 1, 0, 0); v.is_st = 1;
        apply(v);
        step();
        apply(stim(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_pulse("store", 0, 1, 0);
        chk("store commit_rob_pos", 32'(bus.commit_rob_pos), 0);
        apply(stim(1, 4, 1, 1, 32'h44, 0, 0, 0));
        step();
        chk("store rob_tail", 32'(bus.rob_tail), 2);
        rdy = 1'b0;
        apply(stim(1, 12, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pulse($sformatf("frz%0d", i), 0, 0, 0);
            chk($sformatf("frz%0d rob_tail", i), 32'(bus.rob_tail), 2);
        end
        rdy = 1'b1;
        apply(stim(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_pulse("thaw", 1, 0, 0);
        chk("thaw commit_rd", 32'(bus.commit_rd), 4);
        chk("thaw commit_val", bus.commit_val, 32'h44);
        chk("thaw commit_rob_pos", 32'(bus.commit_rob_pos), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
